// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that stalls IF/ID on reads of results not yet available
module hazard_scoreboard #(
  parameter int REG_AW     = 4,
  parameter int NUM_REGS   = 16,
  parameter int FORWARD_EN = 1,
  parameter int LOAD_LAT   = 1,
  parameter int WB_LAT     = 3,
  parameter int SC_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                Two_src,
  input  logic [REG_AW-1:0]   src1,
  input  logic [REG_AW-1:0]   src2,
  input  logic [REG_AW-1:0]   id_dest,
  input  logic                id_wb_en,
  input  logic                id_mem_r_en,
  input  logic                freeze,
  input  logic                flush,
  output logic                hazard_detected,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [SC_W-1:0]     stall_count
);
  localparam logic [3:0] LAT = 4'(FORWARD_EN != 0 ? LOAD_LAT : WB_LAT);
  logic [3:0]      timer_q [NUM_REGS];
  logic [3:0]      timer_d [NUM_REGS];
  logic [SC_W-1:0] stall_count_q, stall_count_d;
  logic            issue;
  always_comb begin
    hazard_detected = id_valid & ~flush & ((timer_q[src1] != 4'd0) | (Two_src & (timer_q[src2] != 4'd0)));
    issue = id_valid & ~flush & ~freeze & ~hazard_detected & id_wb_en & (id_mem_r_en | (FORWARD_EN == 0));
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = timer_q[r] != 4'd0;
      // a reload on issue takes priority over the same-cycle decrement
      timer_d[r] = (issue && id_dest == REG_AW'(r)) ? LAT :
                   (!freeze && busy_mask[r]) ? timer_q[r] - 4'd1 : timer_q[r];
    end
    stall_count_d = (id_valid & hazard_detected & ~freeze & ~&stall_count_q) ? stall_count_q + 1'b1 : stall_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) timer_q[r] <= 4'd0;
      stall_count_q <= '0;
    end else begin
      timer_q       <= timer_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign stall_count = stall_count_q;
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-stage load-use hazard detector.
- Tracks in-flight destination registers in a per-register scoreboard with countdown timers, so result latency is configurable.
- Asserts a stall to the IF/ID stages while a decoding instruction reads a register whose producer result is not yet available.
- Sits beside the ID stage. Two modes: forwarding enabled (only loads create hazards) or no forwarding (every register write creates a hazard until writeback).

Parameters:
- REG_AW, 4, register address width.
- NUM_REGS, 16, scoreboard entries (must equal 2**REG_AW).
- FORWARD_EN, 1, 1 = only loads (wb_en & mem_r_en) are tracked; 0 = every wb_en instruction is tracked.
- LOAD_LAT, 1, cycles a tracked load blocks consumers (FORWARD_EN=1); legal range 1..15.
- WB_LAT, 3, cycles any tracked write blocks consumers (FORWARD_EN=0); legal range 1..15.
- SC_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- Two_src  in  1  instruction reads src2 in addition to src1.
- src1  in  REG_AW  first source register.
- src2  in  REG_AW  second source register.
- id_dest  in  REG_AW  destination register of the ID instruction.
- id_wb_en  in  1  ID instruction writes id_dest.
- id_mem_r_en  in  1  ID instruction is a load.
- freeze  in  1  pipeline frozen (memory not ready): no issue, timers hold.
- flush  in  1  branch taken: the ID instruction is squashed and does not issue.
- hazard_detected  out  1  stall IF/ID this cycle (combinational from state and ID inputs).
- busy_mask  out  NUM_REGS  bit r set when timer[r] != 0.
- stall_count  out  SC_W  saturating count of stall cycles.

Behaviour:
- State:
  - timer[r], 4 bits, one per register.
  - stall_count register.
- Reset (rst=1 at edge): all timers = 0, stall_count = 0; hence busy_mask = 0 and hazard_detected = 0 for the following cycle.
  - Reset overrides issue, freeze and flush in the same cycle.
- Hazard:
  - hazard_detected = id_valid & ~flush & ( (timer[src1]!=0) | (Two_src & timer[src2]!=0) ).
  - src2 is ignored when Two_src=0.
  - freeze does not mask hazard_detected.
- Issue:
  - issue = id_valid & ~flush & ~freeze & ~hazard_detected & id_wb_en & (id_mem_r_en | ~FORWARD_EN).
  - On issue, timer[id_dest] <= (FORWARD_EN ? LOAD_LAT : WB_LAT).
- Countdown:
  - When freeze=0, every nonzero timer not being written by issue decrements by 1.
  - When freeze=1, all timers hold.
  - Timers never wrap below 0.
- Simultaneous events:
  - Issue to register r wins over the decrement of r in the same cycle (reload, no decrement).
  - An instruction whose id_dest equals its own source:
    - if the source is busy, it stalls and does not issue;
    - otherwise it issues normally.
- Latency:
  - Load issued at cycle t with LOAD_LAT=1 makes a dependent instruction in ID at t+1 see hazard_detected=1.
  - At t+2 the hazard is clear: exactly one bubble.
  - In general, LOAD_LAT (or WB_LAT) bubbles when the consumer immediately follows.
- Flush:
  - A flushed instruction never sets a timer.
  - Existing timers continue counting; older in-flight producers are not squashed.
- stall_count:
  - Increments when id_valid & hazard_detected & ~freeze.
  - Saturates at all-ones; no wrap.
- busy_mask is a registered-state decode; no combinational path from ID inputs.

Test Plan:
- FORWARD_EN=1, LOAD_LAT=1: load R3 at t (id_valid=1, wb_en=1, mem_r_en=1, dest=3), then ADD src1=3 at t+1 -> hazard_detected=1 at t+1 only, 0 at t+2; busy_mask=0x0008 at t+1; stall_count=1.
- FORWARD_EN=1: non-load write R5, then consumer src1=5 -> hazard_detected stays 0; busy_mask stays 0. Also Two_src=0, src2=3 with R3 busy -> no hazard.
- FORWARD_EN=0, WB_LAT=3: write R2, consumer src2=2 with Two_src=1 -> hazard_detected=1 for 3 consecutive cycles; stall_count=3.
- LOAD_LAT=2: load R4; freeze=1 for 5 cycles starting the cycle after issue -> timer[4] holds at 2, hazard stays 1, stall_count unchanged during freeze; after release, hazard clears 2 cycles later.
- Load R7 with flush=1 -> busy_mask stays 0. Back-to-back loads to R7 (second reissued when timer=1) -> timer reloads to LOAD_LAT rather than decrementing.
- rst=1 mid-operation with busy_mask=0x0090 and stall_count=9 -> next cycle busy_mask=0, stall_count=0, hazard_detected=0. Drive 2**SC_W+2 stall cycles (SC_W=4) -> stall_count holds at 15.
